// File: rtl/note_hit_judge.sv
// note_hit_judge: per-lane note queues judged against a hit line, with score and combo counters
module note_hit_judge #(
  parameter int LANES    = 3,
  parameter int DEPTH    = 4,
  parameter int POS_W    = 9,
  parameter int HIT_LINE = 430,
  parameter int WINDOW   = 20,
  parameter int MISS_POS = 490,
  parameter int SCORE_W  = 8
) (
  input  logic               board_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               step_tick,
  input  logic [LANES-1:0]   spawn,
  input  logic [LANES-1:0]   press,
  output logic [LANES-1:0]   hit,
  output logic [LANES-1:0]   miss,
  output logic [LANES-1:0]   stray,
  output logic [LANES-1:0]   overflow,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] combo,
  output logic [SCORE_W-1:0] max_combo
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(LANES + 1);
  localparam logic [POS_W-1:0] LO   = POS_W'(HIT_LINE - WINDOW);
  localparam logic [POS_W-1:0] HI   = POS_W'(HIT_LINE + WINDOW);
  localparam logic [POS_W-1:0] MP   = POS_W'(MISS_POS);
  localparam logic [POS_W-1:0] PMAX = '1;
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  logic [POS_W-1:0] mem [LANES][DEPTH];
  logic [POS_W-1:0] mem_n [LANES][DEPTH];
  logic [PW-1:0] hd [LANES];
  logic [PW-1:0] hd_n [LANES];
  logic [PW-1:0] tl [LANES];
  logic [CW-1:0] cnt [LANES];
  logic [CW-1:0] cnt_n [LANES];
  logic [LANES-1:0] hit_n, miss_n, stray_n, ovf_n, pop, push;
  logic [NW-1:0] nhits;
  logic [SCORE_W:0] score_sum, combo_sum;
  logic [SCORE_W-1:0] score_n, combo_n, max_n;
  always_comb begin
    hit_n   = '0;
    miss_n  = '0;
    stray_n = '0;
    ovf_n   = '0;
    pop     = '0;
    push    = '0;
    nhits   = '0;
    hd_n    = hd;
    cnt_n   = cnt;
    tl      = hd;
    mem_n   = mem;
    for (int l = 0; l < LANES; l++) begin
      hit_n[l]   = enable && press[l] && cnt[l] != '0 && mem[l][hd[l]] >= LO && mem[l][hd[l]] <= HI;
      stray_n[l] = enable && press[l] && !hit_n[l];
      miss_n[l]  = enable && step_tick && !hit_n[l] && cnt[l] != '0 && mem[l][hd[l]] >= MP;
      pop[l]     = hit_n[l] || miss_n[l];
      ovf_n[l]   = enable && spawn[l] && cnt[l] == FULL && !pop[l];
      push[l]    = enable && spawn[l] && !ovf_n[l];
      hd_n[l]    = hd[l] + PW'(pop[l]);
      cnt_n[l]   = cnt[l] - CW'(pop[l]) + CW'(push[l]);
      tl[l]      = hd[l] + cnt[l][PW-1:0];
      nhits      = nhits + NW'(hit_n[l]);
      // a full lane that pops this cycle reuses the freed head slot as its new tail
      for (int j = 0; j < DEPTH; j++) begin
        mem_n[l][j] = (enable && step_tick && mem[l][j] != PMAX) ? mem[l][j] + 1'b1 : mem[l][j];
        if (push[l] && tl[l] == PW'(j)) mem_n[l][j] = '0;
      end
    end
    score_sum = {1'b0, score} + (SCORE_W+1)'(nhits);
    combo_sum = {1'b0, combo} + (SCORE_W+1)'(nhits);
    score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_n   = |(miss_n | stray_n) ? '0 : (combo_sum[SCORE_W] ? '1 : combo_sum[SCORE_W-1:0]);
    max_n     = combo_n > max_combo ? combo_n : max_combo;
  end
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      mem       <= '{default: '0};
      hd        <= '{default: '0};
      cnt       <= '{default: '0};
      hit       <= '0;
      miss      <= '0;
      stray     <= '0;
      overflow  <= '0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      mem       <= mem_n;
      hd        <= hd_n;
      cnt       <= cnt_n;
      hit       <= hit_n;
      miss      <= miss_n;
      stray     <= stray_n;
      overflow  <= ovf_n;
      score     <= score_n;
      combo     <= combo_n;
      max_combo <= max_n;
    end
  end
endmodule

// File: tb/tb_note_hit_judge.sv
// tb_note_hit_judge: queue-based reference model feeding a per-cycle scoreboard, plus directed checks
module tb_note_hit_judge;
  logic       board_clk = 0;
  logic       reset = 1;
  logic       enable = 0;
  logic       step_tick = 0;
  logic [2:0] spawn = 0;
  logic [2:0] press = 0;
  logic [2:0] hit, miss, stray, overflow;
  logic [7:0] score, combo, max_combo;
  int tests = 0;
  int failed = 0;
  logic [35:0] sb[$];
  int mq[3][$];
  int m_score, m_combo, m_max;

  note_hit_judge dut (
    .board_clk(board_clk), .reset(reset), .enable(enable), .step_tick(step_tick),
    .spawn(spawn), .press(press), .hit(hit), .miss(miss), .stray(stray),
    .overflow(overflow), .score(score), .combo(combo), .max_combo(max_combo)
  );

  always #5 board_clk = ~board_clk;

  function automatic logic [35:0] obs();
    return {hit, miss, stray, overflow, score, combo, max_combo};
  endfunction

  task automatic check(string tag, logic [35:0] got, logic [35:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(logic en, logic [2:0] sp, logic [2:0] pr, logic st, output logic [35:0] e);
    logic [2:0] h, m, s, o;
    int n;
    h = 0; m = 0; s = 0; o = 0; n = 0;
    if (en) begin
      for (int l = 0; l < 3; l++) begin
        h[l] = pr[l] && mq[l].size() > 0 && mq[l][0] >= 410 && mq[l][0] <= 450;
        s[l] = pr[l] && !h[l];
        m[l] = st && !h[l] && mq[l].size() > 0 && mq[l][0] >= 490;
        if (h[l] || m[l]) void'(mq[l].pop_front());
        if (st) for (int k = 0; k < mq[l].size(); k++) if (mq[l][k] < 511) mq[l][k]++;
        o[l] = sp[l] && mq[l].size() == 4;
        if (sp[l] && !o[l]) mq[l].push_back(0);
        n += int'(h[l]);
      end
      m_score = (m_score + n > 255) ? 255 : m_score + n;
      if (|(m | s)) m_combo = 0;
      else m_combo = (m_combo + n > 255) ? 255 : m_combo + n;
      if (m_combo > m_max) m_max = m_combo;
    end
    e = {h, m, s, o, 8'(m_score), 8'(m_combo), 8'(m_max)};
  endtask

  task automatic drive(logic en, logic [2:0] sp, logic [2:0] pr, logic st);
    logic [35:0] e;
    @(negedge board_clk);
    enable = en; spawn = sp; press = pr; step_tick = st;
    model(en, sp, pr, st, e);
    sb.push_back(e);
    @(posedge board_clk);
    #2;
    spawn = 0; press = 0; step_tick = 0; enable = 1;
  endtask

  task automatic ticks(int n);
    repeat (n) drive(1, 3'b000, 3'b000, 1);
  endtask

  task automatic do_reset(string tag);
    @(negedge board_clk);
    reset = 1;
    for (int l = 0; l < 3; l++) mq[l].delete();
    m_score = 0; m_combo = 0; m_max = 0;
    #1;
    check(tag, obs(), 36'h0);
    repeat (2) @(negedge board_clk);
    reset = 0;
  endtask

  always @(posedge board_clk) begin
    #1;
    if (sb.size() > 0) check("cyc", obs(), sb.pop_front());
  end

  initial begin
    do_reset("rst0");
    // 1: hit exactly on the line, then press on an empty lane
    drive(1, 3'b001, 3'b000, 0);
    ticks(430);
    drive(1, 3'b000, 3'b001, 0);
    check("t1_hit", 36'(hit), 36'(3'b001));
    check("t1_cnt", 36'({score, combo, max_combo}), 36'({8'd1, 8'd1, 8'd1}));
    drive(1, 3'b000, 3'b001, 0);
    check("t1_empty", 36'({hit, stray}), 36'({3'b000, 3'b001}));
    // 2: one pixel below the window, then the lower edge
    do_reset("rst2");
    drive(1, 3'b010, 3'b000, 0);
    ticks(409);
    drive(1, 3'b000, 3'b010, 0);
    check("t2_stray", 36'({stray, combo}), 36'({3'b010, 8'd0}));
    ticks(1);
    drive(1, 3'b000, 3'b010, 0);
    check("t2_hit", 36'({hit, score}), 36'({3'b010, 8'd1}));
    // 3: miss on the step taken from MISS_POS
    do_reset("rst3");
    drive(1, 3'b001, 3'b000, 0);
    ticks(430);
    drive(1, 3'b100, 3'b001, 0);
    ticks(490);
    check("t3_nomiss", 36'(miss), 36'(3'b000));
    ticks(1);
    check("t3_miss", 36'({miss, score, combo}), 36'({3'b100, 8'd1, 8'd0}));
    // 4: overflow on a full lane, accepted when a hit frees a slot
    do_reset("rst4");
    repeat (4) drive(1, 3'b001, 3'b000, 0);
    check("t4_noovf", 36'(overflow), 36'(3'b000));
    drive(1, 3'b001, 3'b000, 0);
    check("t4_ovf", 36'(overflow), 36'(3'b001));
    ticks(430);
    drive(1, 3'b001, 3'b001, 0);
    check("t4_swap", 36'({hit, overflow}), 36'({3'b001, 3'b000}));
    drive(1, 3'b001, 3'b000, 0);
    check("t4_full", 36'(overflow), 36'(3'b001));
    // 5: all lanes at once, then lane1 out of window
    do_reset("rst5");
    drive(1, 3'b111, 3'b000, 0);
    ticks(430);
    drive(1, 3'b000, 3'b111, 0);
    check("t5_all", 36'({hit, score, combo}), 36'({3'b111, 8'd3, 8'd3}));
    drive(1, 3'b101, 3'b000, 0);
    ticks(130);
    drive(1, 3'b010, 3'b000, 0);
    ticks(300);
    drive(1, 3'b000, 3'b111, 0);
    check("t5_mix", 36'({hit, stray, score, combo, max_combo}),
          36'({3'b101, 3'b010, 8'd5, 8'd0, 8'd3}));
    // 6: reset mid-game drops queued notes sitting on the hit line
    do_reset("rst6");
    drive(1, 3'b111, 3'b000, 0);
    ticks(430);
    drive(1, 3'b011, 3'b111, 0);
    ticks(430);
    drive(1, 3'b111, 3'b011, 0);
    check("t6_combo", 36'(combo), 36'(8'd5));
    ticks(430);
    do_reset("t6_rst");
    drive(1, 3'b000, 3'b111, 0);
    check("t6_after", 36'({hit, stray, score}), 36'({3'b000, 3'b111, 8'd0}));
    // 7: enable low freezes positions and ignores inputs
    drive(1, 3'b001, 3'b000, 0);
    ticks(430);
    drive(0, 3'b001, 3'b001, 1);
    check("t7_frz", 36'({hit, stray, overflow}), 36'(9'd0));
    repeat (30) drive(0, 3'b000, 3'b000, 1);
    drive(1, 3'b000, 3'b001, 0);
    check("t7_hit", 36'(hit), 36'(3'b001));
    repeat (3) @(negedge board_clk);
    check("sb_empty", 36'(sb.size()), 36'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
